// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: credit-limited sequential prefetch into a small FIFO, redirect on branch.
// Optional build macro PERF_CNT_EN adds delivered/dropped instruction counters.
module if_prefetch_stage #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  aq_rd_ptr;
  logic [PTR_W-1:0]  aq_wr_ptr;

  logic [ADDR_W-1:0] aq_pc     [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

  logic grant;
  logic resp_drop;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_empty;
  logic fifo_full;
  logic unused_addr_lsb;

  // Every FIFO slot is either filled or promised to an in-flight request,
  // so a granted response can never find the FIFO full.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req    = !rst && !branch_taken && (credit_used < {1'b0, DEPTH_C});
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  assign resp_drop  = imem_rvalid && (branch_taken || (discard_cnt != '0));
  assign fifo_push  = imem_rvalid && !resp_drop;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C);

  assign out_valid = !fifo_empty && !branch_taken;
  assign fifo_pop  = out_valid && out_ready;
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_data[rd_ptr];

  assign unused_addr_lsb = ^branch_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      fetch_pc <= {branch_addr[ADDR_W-1:2], 2'b00};
    end else if (grant) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({grant, imem_rvalid})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // On redirect every request still in flight becomes stale; a response
  // landing in the redirect cycle is dropped directly and not counted again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_cnt <= '0;
    end else if (branch_taken) begin
      discard_cnt <= outstanding - CNT_W'(imem_rvalid);
    end else if (imem_rvalid && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - ONE_C;
    end
  end

  // In-order queue of fetch_addr+4 for each granted request, consumed by
  // every response whether kept or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_wr_ptr <= '0;
      aq_rd_ptr <= '0;
    end else begin
      if (grant) begin
        aq_wr_ptr <= aq_wr_ptr + PTR_W'(1);
      end
      if (imem_rvalid) begin
        aq_rd_ptr <= aq_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      aq_pc[aq_wr_ptr] <= fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else if (fifo_push) begin
      fifo_pc[wr_ptr]   <= aq_pc[aq_rd_ptr];
      fifo_data[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (branch_taken) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + ONE_C;
        2'b01:   fifo_count <= fifo_count - ONE_C;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      if (fifo_pop) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (resp_drop) begin
        dropped_q <= dropped_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`else
  assign perf_fetched = '0;
  assign perf_dropped = '0;
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: latency-programmable memory model,
// expected {pc+4, instr} queued at each grant and matched on each ID handshake.
module tb_if_prefetch_stage;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;

  if_prefetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t pend[$];
  exp_t  sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  int          cyc;
  int          lat;
  bit          gnt_on;
  bit          ready_on;
  bit          br_now;
  logic [31:0] br_target;
  logic [31:0] mpc;
  int          grants;
  int          pops;
  int          first_valid_cyc;
  bit          first_pending;
  logic [31:0] first_pc;
  bit          saw_wrap;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: drive at negedge, settle, observe handshakes before the posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr >> 2;
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    branch_taken = br_now;
    branch_addr  = br_target;
    imem_gnt     = gnt_on;
    out_ready    = ready_on;
    #1;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (branch_taken) begin
      check_eq("br_no_valid", out_valid, 1'b0);
      check_eq("br_no_req", imem_req, 1'b0);
      sb.delete();
      mpc = {branch_addr[31:2], 2'b00};
      first_pending = 1'b1;
    end else begin
      if (imem_req && imem_gnt) begin
        check_eq("fetch_addr", imem_addr, mpc);
        pend.push_back('{addr: imem_addr, due: cyc + lat});
        sb.push_back('{pc: mpc + 32'd4, instr: mpc >> 2});
        mpc = mpc + 32'd4;
        grants++;
      end
      if (out_valid && out_ready) begin
        pops++;
        if (out_pc == 32'd0) saw_wrap = 1'b1;
        if (first_pending) begin
          first_pc = out_pc;
          first_pending = 1'b0;
        end
        if (sb.size() == 0) begin
          check_eq("unexpected_pop", out_pc, 64'hdead_0000);
        end else begin
          e = sb.pop_front();
          check_eq("out_pc", out_pc, e.pc);
          check_eq("out_instr", out_instr, e.instr);
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br_now = 1'b0; br_target = '0; gnt_on = 1'b0; ready_on = 1'b0;
    branch_taken = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
    pend.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_pc", out_pc, 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    check_eq("rst_perf_f", perf_fetched, 32'd0);
    check_eq("rst_perf_d", perf_dropped, 32'd0);
    rst = 1'b0;
    mpc = 32'd0;
    cyc = 0; grants = 0; pops = 0;
    first_valid_cyc = -1; first_pending = 1'b0; first_pc = '0; saw_wrap = 1'b0;
  endtask

  task automatic drain();
    gnt_on = 1'b0;
    ready_on = 1'b1;
    br_now = 1'b0;
    for (int i = 0; i < 60 && (pend.size() > 0 || sb.size() > 0); i++) step();
    check_eq("drain_sb_empty", sb.size(), 0);
    check_eq("drain_mem_empty", pend.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pops_before;

    // Streaming, latency 1, full throughput
    do_reset();
    lat = 1; gnt_on = 1'b1; ready_on = 1'b1;
    repeat (20) step();
    check_eq("first_valid_cyc", first_valid_cyc, 2);
    check_eq("stream_pops", pops, 18);
    drain();
    check_eq("perf_fetched_t1", perf_fetched, PERF ? pops : 0);

    // ID stalled: credits exhaust after FIFO_DEPTH requests, head held
    do_reset();
    lat = 1; gnt_on = 1'b1; ready_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) check_eq("hold_pc", out_pc, 32'd4);
    end
    check_eq("stall_grants", grants, 4);
    check_eq("stall_req_low", imem_req, 1'b0);
    gnt_on = 1'b0; ready_on = 1'b1;
    pops_before = pops;
    repeat (4) step();
    check_eq("release_pops", pops - pops_before, 4);
    drain();

    // Branch with 3 in flight at latency 3
    do_reset();
    lat = 3; gnt_on = 1'b1; ready_on = 1'b1;
    repeat (3) step();
    br_now = 1'b1; br_target = 32'h100;
    step();
    br_now = 1'b0;
    repeat (6) step();
    drain();
    check_eq("t3_first_pc", first_pc, 32'h104);
    check_eq("t3_dropped", perf_dropped, PERF ? 3 : 0);

    // Branch coinciding with rvalid and a would-be pop
    do_reset();
    lat = 2; gnt_on = 1'b1; ready_on = 1'b1;
    repeat (6) step();
    check_eq("t4_pre_valid", out_valid, 1'b1);
    br_now = 1'b1; br_target = 32'h403;
    step();
    br_now = 1'b0;
    repeat (6) step();
    drain();
    check_eq("t4_first_pc", first_pc, 32'h404);
    check_eq("t4_dropped", perf_dropped, PERF ? 2 : 0);
    check_eq("t4_fetched", perf_fetched, PERF ? pops : 0);

    // Two branches with one cycle between them
    do_reset();
    lat = 3; gnt_on = 1'b1; ready_on = 1'b1;
    repeat (2) step();
    br_now = 1'b1; br_target = 32'h200;
    step();
    br_now = 1'b0;
    step();
    br_now = 1'b1; br_target = 32'h300;
    step();
    br_now = 1'b0;
    repeat (6) step();
    drain();
    check_eq("t5_first_pc", first_pc, 32'h304);
    check_eq("t5_dropped", perf_dropped, PERF ? 3 : 0);

    // Address wrap, then async reset mid-burst
    do_reset();
    lat = 1; gnt_on = 1'b1; ready_on = 1'b1;
    br_now = 1'b1; br_target = 32'hFFFF_FFF4;
    step();
    br_now = 1'b0;
    repeat (8) step();
    check_eq("wrap_seen", saw_wrap, 1'b1);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid, 1'b0);
    check_eq("async_rst_req", imem_req, 1'b0);
    check_eq("async_rst_pc", out_pc, 32'd0);
    do_reset();
    lat = 1; gnt_on = 1'b1; ready_on = 1'b1;
    repeat (5) step();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
